// File: rtl/state_dump_engine.sv
// Snapshot/end-of-run dump unit: freezes the core on halt or trigger, then streams every
// register, the selected memory words and an end marker over a valid/ready record port.
module state_dump_engine #(
  parameter int unsigned         DATA_W      = 16,
  parameter int unsigned         INSTR_W     = 16,
  parameter int unsigned         REG_COUNT   = 16,
  parameter int unsigned         REG_ADDR_W  = 4,
  parameter int unsigned         MEM_ADDR_W  = 16,
  parameter logic [INSTR_W-1:0]  HALT_MASK   = 16'hF800,
  parameter logic [INSTR_W-1:0]  HALT_OPCODE = 16'hE000,
  parameter bit                  SKIP_ZERO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  instr_valid,
  input  logic                  trigger,
  output logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0]     reg_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_kind,
  output logic [MEM_ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  cpu_stall,
  output logic                  halted,
  output logic                  done
);

  typedef enum logic [2:0] {
    StIdle, StRegScan, StMemRd, StMemChk, StEmit, StEnd, StDone
  } state_e;

  localparam logic [1:0]            KindReg = 2'b00;
  localparam logic [1:0]            KindMem = 2'b01;
  localparam logic [1:0]            KindEnd = 2'b10;
  localparam logic [REG_ADDR_W-1:0] RegLast = REG_ADDR_W'(REG_COUNT - 1);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] reg_cnt_q, reg_cnt_d;
  logic [MEM_ADDR_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [DATA_W-1:0]     emit_cnt_q, emit_cnt_d;
  logic                  mem_re_q, mem_re_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            out_kind_q, out_kind_d;
  logic [MEM_ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  done_q, done_d;
  logic                  halt_hit;

  assign halt_hit = instr_valid && ((instr & HALT_MASK) == HALT_OPCODE);

  always_comb begin
    state_d     = state_q;
    reg_cnt_d   = reg_cnt_q;
    mem_cnt_d   = mem_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    mem_re_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_kind_d  = out_kind_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;
    done_d      = done_q;
    case (state_q)
      StIdle: begin
        if (halt_hit || trigger) begin
          halted_d   = halt_hit;
          reg_cnt_d  = '0;
          emit_cnt_d = '0;
          state_d    = StRegScan;
        end
      end
      StRegScan: begin
        out_valid_d = 1'b1;
        out_kind_d  = KindReg;
        out_index_d = MEM_ADDR_W'(reg_cnt_q);
        out_data_d  = reg_rdata;
        state_d     = StEmit;
      end
      StMemRd: state_d = StMemChk;
      StMemChk: begin
        if (!SKIP_ZERO || (mem_rdata != '0)) begin
          out_valid_d = 1'b1;
          out_kind_d  = KindMem;
          out_index_d = mem_cnt_q;
          out_data_d  = mem_rdata;
          emit_cnt_d  = (&emit_cnt_q) ? emit_cnt_q : emit_cnt_q + 1'b1;
          state_d     = StEmit;
        end else if (&mem_cnt_q) begin
          state_d = StEnd;
        end else begin
          mem_cnt_d = mem_cnt_q + 1'b1;
          mem_re_d  = 1'b1;
          state_d   = StMemRd;
        end
      end
      StEmit: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // The kind of the record just accepted tells us which scan step resumes.
          case (out_kind_q)
            KindReg: begin
              if (reg_cnt_q == RegLast) begin
                mem_cnt_d = '0;
                mem_re_d  = 1'b1;
                state_d   = StMemRd;
              end else begin
                reg_cnt_d = reg_cnt_q + 1'b1;
                state_d   = StRegScan;
              end
            end
            KindMem: begin
              if (&mem_cnt_q) begin
                state_d = StEnd;
              end else begin
                mem_cnt_d = mem_cnt_q + 1'b1;
                mem_re_d  = 1'b1;
                state_d   = StMemRd;
              end
            end
            default: begin
              done_d  = halted_q;
              state_d = halted_q ? StDone : StIdle;
            end
          endcase
        end
      end
      StEnd: begin
        out_valid_d = 1'b1;
        out_kind_d  = KindEnd;
        out_index_d = '0;
        out_data_d  = emit_cnt_q;
        state_d     = StEmit;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    busy_d = !((state_d == StIdle) || (state_d == StDone));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      reg_cnt_q   <= '0;
      mem_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      mem_re_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_kind_q  <= 2'b00;
      out_index_q <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_cnt_q   <= reg_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      mem_re_q    <= mem_re_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
    end
  end

  assign reg_addr  = reg_cnt_q;
  assign mem_addr  = mem_cnt_q;
  assign mem_re    = mem_re_q;
  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign cpu_stall = busy_q;
  assign halted    = halted_q;
  assign done      = done_q;

endmodule

// File: tb/tb_state_dump_engine.sv
// Bench for state_dump_engine: two instances (sparse 8-bit memory, dense 4-bit memory) checked
// against an expected record list derived from register/memory contents.
module tb_state_dump_engine;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] idx;
    logic [15:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid_a, instr_valid_b, trigger_a, trigger_b, ready_a, ready_b;

  logic [3:0]  reg_addr_a, reg_addr_b;
  logic [15:0] reg_rdata_a, reg_rdata_b, mem_rdata_a, mem_rdata_b;
  logic [7:0]  mem_addr_a, out_index_a;
  logic [3:0]  mem_addr_b, out_index_b;
  logic        mem_re_a, mem_re_b, out_valid_a, out_valid_b;
  logic [1:0]  out_kind_a, out_kind_b;
  logic [15:0] out_data_a, out_data_b;
  logic        busy_a, busy_b, stall_a, stall_b, halted_a, halted_b, done_a, done_b;

  logic [15:0] regs  [16];
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [16];
  rec_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign reg_rdata_a = regs[reg_addr_a];
  assign reg_rdata_b = regs[reg_addr_b];
  always @(posedge clk) begin
    if (mem_re_a) mem_rdata_a <= mem_a[mem_addr_a];
    if (mem_re_b) mem_rdata_b <= mem_b[mem_addr_b];
  end

  state_dump_engine #(.MEM_ADDR_W(8), .SKIP_ZERO(1'b1)) dut_a (
    .clk(clk), .reset(rst_n), .instr(instr), .instr_valid(instr_valid_a), .trigger(trigger_a),
    .reg_addr(reg_addr_a), .reg_rdata(reg_rdata_a), .mem_addr(mem_addr_a), .mem_re(mem_re_a),
    .mem_rdata(mem_rdata_a), .out_valid(out_valid_a), .out_ready(ready_a),
    .out_kind(out_kind_a), .out_index(out_index_a), .out_data(out_data_a), .busy(busy_a),
    .cpu_stall(stall_a), .halted(halted_a), .done(done_a)
  );

  state_dump_engine #(.MEM_ADDR_W(4), .SKIP_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(rst_n), .instr(instr), .instr_valid(instr_valid_b), .trigger(trigger_b),
    .reg_addr(reg_addr_b), .reg_rdata(reg_rdata_b), .mem_addr(mem_addr_b), .mem_re(mem_re_b),
    .mem_rdata(mem_rdata_b), .out_valid(out_valid_b), .out_ready(ready_b),
    .out_kind(out_kind_b), .out_index(out_index_b), .out_data(out_data_b), .busy(busy_b),
    .cpu_stall(stall_b), .halted(halted_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] k, input int i, input logic [15:0] d);
    rec_t r;
    r.kind = k;
    r.idx  = 16'(i);
    r.data = d;
    return r;
  endfunction

  // Reference: every register, then the memory words that qualify, then the count.
  task automatic build_exp(input int which);
    int n;
    int depth;
    logic [15:0] v;
    n = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(2'b00, i, regs[i]));
    depth = (which == 0) ? 256 : 16;
    for (int a = 0; a < depth; a++) begin
      v = (which == 0) ? mem_a[a[7:0]] : mem_b[a[3:0]];
      if (which == 1 || v != 16'd0) begin
        exp_q.push_back(mk(2'b01, a, v));
        n++;
      end
    end
    exp_q.push_back(mk(2'b10, 0, (n > 65535) ? 16'hFFFF : 16'(n)));
  endtask

  function automatic rec_t cur_rec(input int which);
    if (which == 0) return mk(out_kind_a, int'(out_index_a), out_data_a);
    return mk(out_kind_b, int'(out_index_b), out_data_b);
  endfunction

  function automatic logic cur_valid(input int which);
    return (which == 0) ? out_valid_a : out_valid_b;
  endfunction

  task automatic set_ready(input int which, input logic v);
    if (which == 0) ready_a = v;
    else ready_b = v;
  endtask

  // Consume records against exp_q; stall < 0 picks a random wait per record.
  task automatic drain(input int which, input int stall, input int budget);
    rec_t held, cur;
    bit   have, just_acc;
    int   waited, target, cyc;
    have = 0; just_acc = 0; waited = 0; target = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      cur = cur_rec(which);
      if (just_acc) chk("gap_after_accept", 64'(cur_valid(which)), 64'd0);
      just_acc = 0;
      if (cur_valid(which)) begin
        if (!have) begin
          held = cur; have = 1; waited = 0;
          target = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end else begin
          chk("hold_stable", 64'(cur), 64'(held));
        end
        if (waited >= target) begin
          set_ready(which, 1'b1);
          chk("record", 64'(cur), 64'(exp_q.pop_front()));
          have = 0; just_acc = 1;
        end else begin
          set_ready(which, 1'b0);
          waited++;
        end
      end else begin
        set_ready(which, 1'b0);
      end
    end
    @(negedge clk);
    set_ready(which, 1'b0);
    chk("stream_complete_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_a_zero(input string tag);
    chk(tag, {reg_addr_a, mem_addr_a, mem_re_a, out_valid_a, out_kind_a, out_index_a,
              out_data_a, busy_a, stall_a, halted_a, done_a}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_random_a();
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    for (int a = 0; a < 256; a++) mem_a[a] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd0;
    mem_a[3]   = 16'h1234;
    mem_a[255] = 16'hBEEF;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; instr = 16'd0; instr_valid_a = 0; instr_valid_b = 0;
    trigger_a = 0; trigger_b = 0; ready_a = 0; ready_b = 0;
    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 3);
    for (int a = 0; a < 256; a++) mem_a[a] = 16'd0;
    for (int a = 0; a < 16; a++) mem_b[a] = 16'd0;
    mem_a[5] = 16'd7; mem_a[200] = 16'hFFFF;
    @(negedge clk); @(negedge clk);
    chk_a_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy_a), 64'd0);

    // Basic halt dump, ready always high.
    build_exp(0);
    instr = 16'hE000; instr_valid_a = 1;
    @(negedge clk);
    instr_valid_a = 0;
    chk("halt_busy_halted", {62'd0, busy_a, halted_a}, 64'd3);
    chk("stall_eq_busy", 64'(stall_a), 64'(busy_a));
    chk("no_record_yet", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    chk("first_record_latency", 64'(out_valid_a), 64'd1);
    drain(0, 0, 3000);
    chk("basic_final", {61'd0, done_a, halted_a, busy_a}, 64'b110);

    // Halt masking, then the same dump under 5-cycle backpressure.
    do_reset();
    instr = 16'hE000; instr_valid_a = 0;
    @(negedge clk);
    instr = 16'hF000; instr_valid_a = 1;
    @(negedge clk);
    chk("ignored_nonhalt", {62'd0, busy_a, halted_a}, 64'd0);
    build_exp(0);
    instr = 16'hE7FF;
    @(negedge clk);
    instr_valid_a = 0;
    chk("masked_halt", {62'd0, busy_a, halted_a}, 64'd3);
    drain(0, 5, 5000);
    chk("bp_done", 64'(done_a), 64'd1);

    // Trigger snapshot with a halt presented throughout the dump.
    do_reset();
    fill_random_a();
    build_exp(0);
    trigger_a = 1;
    @(negedge clk);
    trigger_a = 0;
    chk("trig_busy", {62'd0, busy_a, halted_a}, 64'd2);
    instr = 16'hE000; instr_valid_a = 1;
    drain(0, -1, 5000);
    instr_valid_a = 0;
    chk("snap_idle", {61'd0, busy_a, halted_a, done_a}, 64'd0);
    @(negedge clk);
    chk("snap_stays_idle", 64'(busy_a), 64'd0);
    build_exp(0);
    instr_valid_a = 1;
    @(negedge clk);
    instr_valid_a = 0;
    drain(0, -1, 5000);
    chk("later_halt_done", {61'd0, done_a, halted_a, busy_a}, 64'b110);

    // Dense memory instance: every word emitted, last address exactly once.
    for (int a = 0; a < 16; a++) mem_b[a] = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
    mem_b[15] = 16'd9;
    build_exp(1);
    instr_valid_b = 1;
    @(negedge clk);
    instr_valid_b = 0;
    chk("b_busy", {62'd0, busy_b, stall_b}, 64'd3);
    drain(1, -1, 3000);
    chk("b_done", {61'd0, done_b, halted_b, busy_b}, 64'b110);

    // Reset in the middle of the memory phase, then a clean restart.
    do_reset();
    fill_random_a();
    trigger_a = 1;
    @(negedge clk);
    trigger_a = 0;
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (out_valid_a && out_kind_a == 2'b01) found = 1;
      else ready_a = out_valid_a;
    end
    chk("reach_mem_phase", 64'(found), 64'd1);
    ready_a = 0;
    rst_n = 1'b0;
    #1;
    chk_a_zero("mid_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_a_zero("post_reset_idle");
    build_exp(0);
    trigger_a = 1;
    @(negedge clk);
    trigger_a = 0;
    drain(0, -1, 5000);
    chk("restart_final", {61'd0, done_a, halted_a, busy_a}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
